// File: rtl/mem_stage_if.sv
// mem_stage_if: handshake and field bundle between EX, MEM, WB and the data SRAM.
// master drives ex_*/data_sram_*/wb_allowin_in; slave is the mem_stage side.
interface mem_stage_if;
    logic        ex_valid_in;
    logic        mem_allowin_out;
    logic [31:0] ex_PC_in;
    logic [31:0] ex_alures_in;
    logic [31:0] ex_rt_data_in;
    logic [4:0]  ex_wnum_in;
    logic [3:0]  ex_reg_we_in;
    logic [2:0]  ex_load_type_in;
    logic [2:0]  ex_write_type_in;
    logic        data_sram_data_ok_in;
    logic [31:0] data_sram_rdata_in;
    logic        wb_allowin_in;
    logic        mem_valid_out;
    logic [31:0] mem_wbdata_out;
    logic [3:0]  mem_reg_we_out;
    logic [4:0]  mem_wnum_out;
    logic [31:0] mem_PC_out;
    logic [2:0]  mem_write_type_out;

    modport master (
        output ex_valid_in, ex_PC_in, ex_alures_in, ex_rt_data_in,
        output ex_wnum_in, ex_reg_we_in, ex_load_type_in,
        output ex_write_type_in, data_sram_data_ok_in,
        output data_sram_rdata_in, wb_allowin_in,
        input  mem_allowin_out, mem_valid_out, mem_wbdata_out,
        input  mem_reg_we_out, mem_wnum_out, mem_PC_out,
        input  mem_write_type_out
    );

    modport slave (
        input  ex_valid_in, ex_PC_in, ex_alures_in, ex_rt_data_in,
        input  ex_wnum_in, ex_reg_we_in, ex_load_type_in,
        input  ex_write_type_in, data_sram_data_ok_in,
        input  data_sram_rdata_in, wb_allowin_in,
        output mem_allowin_out, mem_valid_out, mem_wbdata_out,
        output mem_reg_we_out, mem_wnum_out, mem_PC_out,
        output mem_write_type_out
    );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; waits for load data, aligns/extends, hands to WB.
// Ports: clk, rst_n (async low), bus (mem_stage_if.slave). Option: MEM_LWLR_EN.
module mem_stage (
    input  logic         clk,
    input  logic         rst_n,
    mem_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_WAIT,
        S_READY
    } state_t;

    localparam logic [2:0] LT_NONE = 3'd0;
    localparam logic [2:0] LT_LB   = 3'd1;
    localparam logic [2:0] LT_LBU  = 3'd2;
    localparam logic [2:0] LT_LH   = 3'd3;
    localparam logic [2:0] LT_LHU  = 3'd4;
    localparam logic [2:0] LT_LW   = 3'd5;
    localparam logic [2:0] LT_LWL  = 3'd6;
    localparam logic [2:0] LT_LWR  = 3'd7;

    state_t      state_q, state_d;
    logic [31:0] pc_q;
    logic [31:0] alu_q;
    logic [4:0]  wnum_q;
    logic [3:0]  we_q;
    logic [2:0]  lt_q;
    logic [2:0]  wt_q;
    logic [31:0] buf_q;

    logic        ready;
    logic        allowin;
    logic        take;
    logic        cap;

    logic [31:0] rd;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] data;
    logic [3:0]  we;

`ifdef MEM_LWLR_EN
    logic [31:0] rt_q;
`else
    logic        unused_rt;
    assign unused_rt = ^bus.ex_rt_data_in;
`endif

    always_comb begin
        state_d = state_q;
        ready   = (state_q == S_READY) ||
                  (state_q == S_WAIT && bus.data_sram_data_ok_in);
        allowin = (state_q == S_EMPTY) || (ready && bus.wb_allowin_in);
        take    = bus.ex_valid_in && allowin;
        // Response arrives but WB stalls: keep the word for later cycles.
        cap     = (state_q == S_WAIT) && bus.data_sram_data_ok_in &&
                  !bus.wb_allowin_in;
        if (take)
            state_d = (bus.ex_load_type_in == LT_NONE) ? S_READY : S_WAIT;
        else if (ready && bus.wb_allowin_in)
            state_d = S_EMPTY;
        else if (cap)
            state_d = S_READY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_EMPTY;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= '0;
            alu_q  <= '0;
            wnum_q <= '0;
            we_q   <= '0;
            lt_q   <= '0;
            wt_q   <= '0;
            buf_q  <= '0;
`ifdef MEM_LWLR_EN
            rt_q   <= '0;
`endif
        end else begin
            if (take) begin
                pc_q   <= bus.ex_PC_in;
                alu_q  <= bus.ex_alures_in;
                wnum_q <= bus.ex_wnum_in;
                we_q   <= bus.ex_reg_we_in;
                lt_q   <= bus.ex_load_type_in;
                wt_q   <= bus.ex_write_type_in;
`ifdef MEM_LWLR_EN
                rt_q   <= bus.ex_rt_data_in;
`endif
            end
            if (cap)
                buf_q <= bus.data_sram_rdata_in;
        end
    end

    // In WAIT the word comes straight from the SRAM; afterwards from buf_q.
    always_comb begin
        rd = (state_q == S_WAIT) ? bus.data_sram_rdata_in : buf_q;
        rbyte = rd[7:0];
        case (alu_q[1:0])
            2'd0: rbyte = rd[7:0];
            2'd1: rbyte = rd[15:8];
            2'd2: rbyte = rd[23:16];
            2'd3: rbyte = rd[31:24];
            default: rbyte = rd[7:0];
        endcase
        rhalf = alu_q[1] ? rd[31:16] : rd[15:0];
    end

    always_comb begin
        data = alu_q;
        we   = we_q;
        case (lt_q)
            LT_LB:  data = {{24{rbyte[7]}}, rbyte};
            LT_LBU: data = {24'd0, rbyte};
            LT_LH:  data = {{16{rhalf[15]}}, rhalf};
            LT_LHU: data = {16'd0, rhalf};
            LT_LW:  data = rd;
`ifdef MEM_LWLR_EN
            LT_LWL: begin
                case (alu_q[1:0])
                    2'd0: begin data = {rd[7:0], rt_q[23:0]};  we = 4'b1000; end
                    2'd1: begin data = {rd[15:0], rt_q[15:0]}; we = 4'b1100; end
                    2'd2: begin data = {rd[23:0], rt_q[7:0]};  we = 4'b1110; end
                    default: begin data = rd;                  we = 4'b1111; end
                endcase
            end
            LT_LWR: begin
                case (alu_q[1:0])
                    2'd0: begin data = rd;                      we = 4'b1111; end
                    2'd1: begin data = {rt_q[31:24], rd[31:8]};  we = 4'b0111; end
                    2'd2: begin data = {rt_q[31:16], rd[31:16]}; we = 4'b0011; end
                    default: begin data = {rt_q[31:8], rd[31:24]}; we = 4'b0001; end
                endcase
            end
`else
            LT_LWL: data = rd;
            LT_LWR: data = rd;
`endif
            default: data = alu_q;
        endcase
    end

    assign bus.mem_allowin_out    = allowin;
    assign bus.mem_valid_out      = ready;
    assign bus.mem_wbdata_out     = data;
    assign bus.mem_reg_we_out     = ready ? we : 4'b0000;
    assign bus.mem_wnum_out       = wnum_q;
    assign bus.mem_PC_out         = pc_q;
    assign bus.mem_write_type_out = wt_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus stall, back-to-back and reset sequences.
// Expected values for load types 6/7 follow MEM_LWLR_EN when it is defined.
module tb_mem_stage;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    mem_stage_if bus ();

    mem_stage u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       nm;
        logic [2:0]  lt;
        logic [31:0] alu;
        logic [31:0] rt;
        logic [31:0] rd;
        logic [3:0]  we;
        int          dly;
        logic [31:0] ed;
        logic [3:0]  ew;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mkv(string nm, logic [2:0] lt, logic [31:0] alu,
                                 logic [31:0] rt, logic [31:0] rd,
                                 logic [3:0] we, int dly,
                                 logic [31:0] ed, logic [3:0] ew);
        vec_t v;
        v.nm = nm; v.lt = lt; v.alu = alu; v.rt = rt; v.rd = rd;
        v.we = we; v.dly = dly; v.ed = ed; v.ew = ew;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.ex_valid_in          = 1'b0;
        bus.ex_PC_in             = '0;
        bus.ex_alures_in         = '0;
        bus.ex_rt_data_in        = '0;
        bus.ex_wnum_in           = '0;
        bus.ex_reg_we_in         = '0;
        bus.ex_load_type_in      = '0;
        bus.ex_write_type_in     = '0;
        bus.data_sram_data_ok_in = 1'b0;
        bus.data_sram_rdata_in   = '0;
        bus.wb_allowin_in        = 1'b1;
    endtask

    task automatic drive(logic [2:0] lt, logic [31:0] alu, logic [31:0] rt,
                         logic [3:0] we, logic [4:0] wn, logic [31:0] pc,
                         logic [2:0] wt);
        bus.ex_valid_in      = 1'b1;
        bus.ex_load_type_in  = lt;
        bus.ex_alures_in     = alu;
        bus.ex_rt_data_in    = rt;
        bus.ex_reg_we_in     = we;
        bus.ex_wnum_in       = wn;
        bus.ex_PC_in         = pc;
        bus.ex_write_type_in = wt;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst_n = 1'b0;

        vt.push_back(mkv("add",  3'd0, 32'h12345678, 32'h0, 32'h0, 4'hF, 0, 32'h12345678, 4'hF));
        vt.push_back(mkv("alu3", 3'd0, 32'h0000ABCD, 32'h0, 32'h0, 4'h3, 0, 32'h0000ABCD, 4'h3));
        vt.push_back(mkv("lb2",  3'd1, 32'h10000002, 32'h0, 32'h80FF7F01, 4'hF, 2, 32'hFFFFFFFF, 4'hF));
        vt.push_back(mkv("lbu2", 3'd2, 32'h10000002, 32'h0, 32'h80FF7F01, 4'hF, 2, 32'h000000FF, 4'hF));
        vt.push_back(mkv("lb1",  3'd1, 32'h10000001, 32'h0, 32'h80FF7F01, 4'hF, 0, 32'h0000007F, 4'hF));
        vt.push_back(mkv("lb3",  3'd1, 32'h10000003, 32'h0, 32'h80FF7F01, 4'hF, 1, 32'hFFFFFF80, 4'hF));
        vt.push_back(mkv("lh2",  3'd3, 32'h10000002, 32'h0, 32'h80015555, 4'hF, 1, 32'hFFFF8001, 4'hF));
        vt.push_back(mkv("lhu2", 3'd4, 32'h10000002, 32'h0, 32'h80015555, 4'hF, 1, 32'h00008001, 4'hF));
        vt.push_back(mkv("lh3",  3'd3, 32'h10000003, 32'h0, 32'h80015555, 4'hF, 0, 32'hFFFF8001, 4'hF));
        vt.push_back(mkv("lh0",  3'd3, 32'h10000000, 32'h0, 32'h0000F00F, 4'hF, 0, 32'hFFFFF00F, 4'hF));
        vt.push_back(mkv("lw",   3'd5, 32'h10000000, 32'h0, 32'hDEADBEEF, 4'hF, 3, 32'hDEADBEEF, 4'hF));
`ifdef MEM_LWLR_EN
        vt.push_back(mkv("lwl1", 3'd6, 32'h10000001, 32'h11223344, 32'hAABBCCDD, 4'hF, 1, 32'hCCDD3344, 4'hC));
        vt.push_back(mkv("lwl0", 3'd6, 32'h10000000, 32'h11223344, 32'hAABBCCDD, 4'hF, 0, 32'hDD223344, 4'h8));
        vt.push_back(mkv("lwr2", 3'd7, 32'h10000002, 32'h11223344, 32'hAABBCCDD, 4'hF, 1, 32'h1122AABB, 4'h3));
        vt.push_back(mkv("lwr3", 3'd7, 32'h10000003, 32'h11223344, 32'hAABBCCDD, 4'hF, 0, 32'h112233AA, 4'h1));
`else
        vt.push_back(mkv("lwl1", 3'd6, 32'h10000001, 32'h11223344, 32'hAABBCCDD, 4'hF, 1, 32'hAABBCCDD, 4'hF));
        vt.push_back(mkv("lwr2", 3'd7, 32'h10000002, 32'h11223344, 32'hAABBCCDD, 4'h7, 1, 32'hAABBCCDD, 4'h7));
`endif

        // Reset state
        #12;
        chk("rst_valid",   {31'd0, bus.mem_valid_out},   32'd0);
        chk("rst_allowin", {31'd0, bus.mem_allowin_out}, 32'd1);
        chk("rst_we",      {28'd0, bus.mem_reg_we_out},  32'd0);
        chk("rst_wbdata",  bus.mem_wbdata_out,           32'd0);
        chk("rst_wnum",    {27'd0, bus.mem_wnum_out},    32'd0);
        chk("rst_pc",      bus.mem_PC_out,               32'd0);
        chk("rst_wt",      {29'd0, bus.mem_write_type_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: one instruction at a time, WB always ready
        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            drive(vt[i].lt, vt[i].alu, vt[i].rt, vt[i].we, 5'(i + 1),
                  32'h400 + 32'(4 * i), 3'(i));
            @(negedge clk);
            bus.ex_valid_in = 1'b0;
            if (vt[i].lt != 3'd0) begin
                for (int d = 0; d < vt[i].dly; d++) begin
                    #1;
                    chk({vt[i].nm, "_wait_valid"}, {31'd0, bus.mem_valid_out}, 32'd0);
                    chk({vt[i].nm, "_wait_allowin"}, {31'd0, bus.mem_allowin_out}, 32'd0);
                    @(negedge clk);
                end
                bus.data_sram_data_ok_in = 1'b1;
                bus.data_sram_rdata_in   = vt[i].rd;
            end
            #1;
            chk({vt[i].nm, "_valid"}, {31'd0, bus.mem_valid_out}, 32'd1);
            chk({vt[i].nm, "_data"},  bus.mem_wbdata_out, vt[i].ed);
            chk({vt[i].nm, "_we"},    {28'd0, bus.mem_reg_we_out}, {28'd0, vt[i].ew});
            chk({vt[i].nm, "_wnum"},  {27'd0, bus.mem_wnum_out}, 32'(i + 1));
            chk({vt[i].nm, "_pc"},    bus.mem_PC_out, 32'h400 + 32'(4 * i));
            chk({vt[i].nm, "_wt"},    {29'd0, bus.mem_write_type_out}, 32'(i % 8));
            @(negedge clk);
            bus.data_sram_data_ok_in = 1'b0;
            #1;
            chk({vt[i].nm, "_drain"}, {31'd0, bus.mem_valid_out}, 32'd0);
            chk({vt[i].nm, "_drain_we"}, {28'd0, bus.mem_reg_we_out}, 32'd0);
        end

        // Back-to-back non-loads, one per cycle
        @(negedge clk);
        drive(3'd0, 32'hA0000000, 32'h0, 4'hF, 5'd10, 32'h800, 3'd1);
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            #1;
            chk("b2b_valid", {31'd0, bus.mem_valid_out}, 32'd1);
            chk("b2b_allowin", {31'd0, bus.mem_allowin_out}, 32'd1);
            chk("b2b_data", bus.mem_wbdata_out, 32'hA0000000 + 32'(k - 1));
            if (k < 3)
                drive(3'd0, 32'hA0000000 + 32'(k), 32'h0, 4'hF, 5'(10 + k),
                      32'h800 + 32'(4 * k), 3'd1);
            else
                bus.ex_valid_in = 1'b0;
        end
        @(negedge clk);
        #1;
        chk("b2b_end", {31'd0, bus.mem_valid_out}, 32'd0);

        // LW response while WB stalls: buffered word, no new accept
        @(negedge clk);
        drive(3'd5, 32'h20000000, 32'h0, 4'hF, 5'd7, 32'h900, 3'd2);
        @(negedge clk);
        bus.ex_valid_in          = 1'b0;
        bus.wb_allowin_in        = 1'b0;
        bus.data_sram_data_ok_in = 1'b1;
        bus.data_sram_rdata_in   = 32'hCAFEBABE;
        #1;
        chk("stall_first_valid", {31'd0, bus.mem_valid_out}, 32'd1);
        chk("stall_first_data", bus.mem_wbdata_out, 32'hCAFEBABE);
        chk("stall_first_allowin", {31'd0, bus.mem_allowin_out}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus.data_sram_data_ok_in = (c == 1);
            bus.data_sram_rdata_in   = 32'h0BADF00D + 32'(c);
            drive(3'd0, 32'h5555AAAA, 32'h0, 4'h3, 5'd3, 32'hA00, 3'd3);
            #1;
            chk("stall_valid", {31'd0, bus.mem_valid_out}, 32'd1);
            chk("stall_data", bus.mem_wbdata_out, 32'hCAFEBABE);
            chk("stall_we", {28'd0, bus.mem_reg_we_out}, 32'hF);
            chk("stall_wnum", {27'd0, bus.mem_wnum_out}, 32'd7);
            chk("stall_allowin", {31'd0, bus.mem_allowin_out}, 32'd0);
        end
        bus.ex_valid_in          = 1'b0;
        bus.data_sram_data_ok_in = 1'b0;
        bus.wb_allowin_in        = 1'b1;
        #1;
        chk("stall_release_allowin", {31'd0, bus.mem_allowin_out}, 32'd1);
        @(negedge clk);
        #1;
        chk("stall_release_valid", {31'd0, bus.mem_valid_out}, 32'd0);

        // Reset while waiting: later stale data_ok is ignored
        @(negedge clk);
        drive(3'd5, 32'h30000000, 32'h0, 4'hF, 5'd9, 32'hB00, 3'd4);
        @(negedge clk);
        bus.ex_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw_valid", {31'd0, bus.mem_valid_out}, 32'd0);
        chk("rstw_allowin", {31'd0, bus.mem_allowin_out}, 32'd1);
        chk("rstw_pc", bus.mem_PC_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.data_sram_data_ok_in = 1'b1;
        bus.data_sram_rdata_in   = 32'h77777777;
        #1;
        chk("rstw_stale_valid", {31'd0, bus.mem_valid_out}, 32'd0);
        chk("rstw_stale_we", {28'd0, bus.mem_reg_we_out}, 32'd0);
        @(negedge clk);
        bus.data_sram_data_ok_in = 1'b0;
        #1;
        chk("rstw_after_valid", {31'd0, bus.mem_valid_out}, 32'd0);
        chk("rstw_after_data", bus.mem_wbdata_out, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between EX and WB. Holds one instruction, waits for the data-SRAM response on loads, aligns and extends load data, and drives the valid/allowin handshake plus writeback fields (data, byte write-enable, register number, PC, write type) that WB consumes. Non-load instructions pass through with one cycle of stage occupancy.

## Interface
Parameters: none.
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid_in  in  1  EX holds a valid instruction
- mem_allowin_out  out  1  stage can accept from EX this cycle
- ex_PC_in  in  32  instruction PC
- ex_alures_in  in  32  ALU result; load address for loads
- ex_rt_data_in  in  32  old rt value (LWL/LWR merge)
- ex_wnum_in  in  5  destination register
- ex_reg_we_in  in  4  byte write-enable
- ex_load_type_in  in  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR
- ex_write_type_in  in  3  forwarding/hazard class, passed through
- data_sram_data_ok_in  in  1  load response valid (request issued in EX)
- data_sram_rdata_in  in  32  load response word
- wb_allowin_in  in  1  WB can accept
- mem_valid_out  out  1  result valid toward WB
- mem_wbdata_out  out  32  writeback data
- mem_reg_we_out  out  4  byte write-enable toward WB
- mem_wnum_out  out  5  destination register
- mem_PC_out  out  32  PC
- mem_write_type_out  out  3  write type

## Operation
- States: EMPTY, WAIT (load, no response yet), READY (result available).
- Accept when ex_valid_in && mem_allowin_out: latch all ex_* fields; load_type 0 -> READY, else WAIT.
- mem_allowin_out = EMPTY || (ready && wb_allowin_in); ready = READY || (WAIT && data_sram_data_ok_in).
- mem_valid_out = valid && ready. Leaving: ready && wb_allowin_in -> EMPTY, or directly to new state if accepting same edge.
- WAIT with data_ok and !wb_allowin_in: capture rdata into buffer, go READY; later output uses buffer. data_ok ignored in EMPTY/READY.
- Alignment by addr = ex_alures_in[1:0]: LB/LBU select byte addr, sign/zero extend; LH/LHU select half addr[1], ignore addr[0]; LW whole word.
- LWL: addr 0 {b0, rt[23:0]} we 1000; 1 {h0, rt[15:0]} 1100; 2 {rdata[23:0], rt[7:0]} 1110; 3 rdata 1111.
- LWR: addr 0 rdata 1111; 1 {rt[31:24], rdata[31:8]} 0111; 2 {rt[31:16], rdata[31:16]} 0011; 3 {rt[31:8], rdata[31:24]} 0001.
- Other types: mem_reg_we_out = latched ex_reg_we_in; load types replace data only.
- Non-load: mem_wbdata_out = latched ex_alures_in.
- When mem_valid_out = 0: mem_reg_we_out = 0; other outputs hold latched values.
- Address misalignment exceptions out of scope.

## Timing
- Reset (async): state EMPTY, all latched fields and buffer 0; mem_valid_out 0, mem_allowin_out 1, mem_reg_we_out 0, mem_wbdata_out 0, mem_wnum_out 0, mem_PC_out 0, mem_write_type_out 0.
- Non-load: accepted edge N, mem_valid_out high cycle N+1.
- Load: mem_valid_out high in first cycle data_ok seen in WAIT (data combinational from data_sram_rdata_in), else from buffer in subsequent cycles.
- Back-to-back: with wb_allowin_in held 1, one instruction per cycle for non-loads.
- Reset mid-WAIT: drop instruction; a later stale data_ok is ignored.
- Outputs stable while mem_valid_out && !wb_allowin_in.

## Configuration
- MEM_LWLR_EN defined: LWL/LWR merge and byte masks as above.
- Undefined: load types 6/7 behave as LW (full word, latched ex_reg_we_in); ex_rt_data_in unused.

## Test plan
- ADD result 0x12345678, wb_allowin 1 -> next cycle mem_valid_out 1, wbdata 0x12345678, we 1111.
- LB addr 0x...2, rdata 0x80FF7F01, data_ok 2 cycles after accept -> valid only then, wbdata 0xFFFFFFFF; LBU -> 0x000000FF.
- LH addr ...2, rdata 0x8001xxxx -> 0xFFFF8001; LHU -> 0x00008001.
- LW data_ok while wb_allowin 0 for 3 cycles, rdata changes after -> buffered word output, allowin 0 until WB accepts.
- With MEM_LWLR_EN: LWL addr 1, rdata 0xAABBCCDD, rt 0x11223344 -> 0xCCDD3344, we 1100; LWR addr 2 -> 0x1122AABB, we 0011.
- Assert rst_n low in WAIT, then data_ok -> mem_valid_out stays 0, we 0000.
